// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light phase sequencer: FSM states,
// lane direction indices and lamp-pattern helpers.
package tlc_pkg;

    localparam int unsigned NUM_DIR  = 4;
    localparam int unsigned SENSOR_W = 2;
    localparam int unsigned STATE_W  = 3;

    localparam int unsigned DIR_W = 0;
    localparam int unsigned DIR_S = 1;
    localparam int unsigned DIR_E = 2;
    localparam int unsigned DIR_N = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_GREEN  = 3'd1,
        ST_WAIT_Y = 3'd2,
        ST_YELLOW = 3'd3,
        ST_WAIT_G = 3'd4,
        ST_FAULT  = 3'd5
    } tlc_state_e;

    // True when exactly one lamp bit is lit.
    function automatic logic is_one_hot(input logic [NUM_DIR-1:0] v);
        return (v != '0) && ((v & (v - NUM_DIR'(1))) == '0);
    endfunction

endpackage

// File: rtl/tlc_cycle_counter.sv
// Phase up-counter with synchronous clear/enable and a terminal-value compare,
// shared by every sequencer state.
module tlc_cycle_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clock,
    input  logic             i_reset_b,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] count,
    output logic             at_term_c
);

    always_ff @(posedge i_clock) begin
        if (i_reset_b) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_term_c = (count == term);

endmodule

// File: rtl/tlc_phase_sequencer.sv
// Generates the g2y/y2r timer pulses for the light controller: sensor-sized
// green phases, fixed yellow, and a sticky fault when lamps stop following.
module tlc_phase_sequencer
    import tlc_pkg::*;
#(
    parameter int unsigned GREEN_MIN     = 4,
    parameter int unsigned EXT_STEP      = 2,
    parameter int unsigned GREEN_MAX     = 8,
    parameter int unsigned YELLOW_CYCLES = 3,
    parameter int unsigned WAIT_TIMEOUT  = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                i_clock,
    input  logic                i_reset_b,
    input  logic                i_enable,
    input  logic [NUM_DIR-1:0]  i_green,
    input  logic [NUM_DIR-1:0]  i_yellow,
    input  logic [SENSOR_W-1:0] i_w_sensor,
    input  logic [SENSOR_W-1:0] i_s_sensor,
    input  logic [SENSOR_W-1:0] i_e_sensor,
    input  logic [SENSOR_W-1:0] i_n_sensor,
    output logic                o_g2y_timer,
    output logic                o_y2r_timer,
    output logic [STATE_W-1:0]  o_state,
    output logic [CNT_W-1:0]    o_phase_cnt,
    output logic                o_fault
);

    localparam int unsigned TGT_W = CNT_W + 3;

    tlc_state_e          state_q;
    tlc_state_e          state_d;
    logic [CNT_W-1:0]    target_q;
    logic [CNT_W-1:0]    new_target;
    logic [TGT_W-1:0]    ext_target;
    logic [SENSOR_W-1:0] lane_sensor;
    logic                load_target;
    logic                green_ok;
    logic                lamps_green;
    logic                cnt_clr;
    logic                cnt_en;
    logic [CNT_W-1:0]    cnt_term;
    logic                at_term;
    logic                g2y_d;
    logic                y2r_d;
    logic                fault_d;

    assign green_ok    = is_one_hot(i_green);
    assign lamps_green = green_ok && (i_yellow == '0);

    // Sensor of the lane whose green lamp is lit.
    always_comb begin
        lane_sensor = '0;
        if (i_green[DIR_W]) begin
            lane_sensor = i_w_sensor;
        end else if (i_green[DIR_S]) begin
            lane_sensor = i_s_sensor;
        end else if (i_green[DIR_E]) begin
            lane_sensor = i_e_sensor;
        end else if (i_green[DIR_N]) begin
            lane_sensor = i_n_sensor;
        end
    end

    // Wide sum so a large sensor extension saturates instead of wrapping.
    assign ext_target = TGT_W'(GREEN_MIN) + TGT_W'(EXT_STEP) * TGT_W'(lane_sensor);
    assign new_target = (ext_target > TGT_W'(GREEN_MAX)) ? CNT_W'(GREEN_MAX)
                                                         : CNT_W'(ext_target);

    tlc_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .i_clock   (i_clock),
        .i_reset_b (i_reset_b),
        .clear     (cnt_clr),
        .enable    (cnt_en),
        .term      (cnt_term),
        .count     (o_phase_cnt),
        .at_term_c (at_term)
    );

    // Next-state, counter control and pulse decisions.
    always_comb begin
        state_d     = state_q;
        load_target = 1'b0;
        cnt_en      = 1'b0;
        cnt_term    = '0;
        cnt_clr     = 1'b0;
        g2y_d       = 1'b0;
        y2r_d       = 1'b0;
        fault_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_enable && lamps_green) begin
                    state_d     = ST_GREEN;
                    load_target = 1'b1;
                end
            end
            ST_GREEN: begin
                cnt_term = target_q - CNT_W'(1);
                cnt_en   = i_enable;
                if (!green_ok) begin
                    state_d = ST_FAULT;
                end else if (i_enable && at_term) begin
                    state_d = ST_WAIT_Y;
                end
            end
            ST_WAIT_Y: begin
                cnt_term = CNT_W'(WAIT_TIMEOUT - 1);
                cnt_en   = 1'b1;
                if (i_yellow != '0) begin
                    state_d = ST_YELLOW;
                end else if (at_term) begin
                    state_d = ST_FAULT;
                end
            end
            ST_YELLOW: begin
                cnt_term = CNT_W'(YELLOW_CYCLES - 1);
                cnt_en   = 1'b1;
                if (at_term) begin
                    state_d = ST_WAIT_G;
                end
            end
            ST_WAIT_G: begin
                cnt_term = CNT_W'(WAIT_TIMEOUT - 1);
                cnt_en   = 1'b1;
                if (lamps_green) begin
                    state_d     = ST_GREEN;
                    load_target = 1'b1;
                end else if (at_term) begin
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every state starts its phase count from zero.
        cnt_clr = (state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_FAULT);
        g2y_d   = (state_q == ST_GREEN)  && (state_d == ST_WAIT_Y);
        y2r_d   = (state_q == ST_YELLOW) && (state_d == ST_WAIT_G);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset_b) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            o_g2y_timer <= 1'b0;
            o_y2r_timer <= 1'b0;
            o_fault     <= 1'b0;
        end else begin
            state_q     <= state_d;
            o_g2y_timer <= g2y_d;
            o_y2r_timer <= y2r_d;
            o_fault     <= fault_d;
            if (load_target) begin
                target_q <= new_target;
            end
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// Self-checking bench for tlc_phase_sequencer: directed vector table, corner
// sequences and randomized phases checked against a phase-level timing model.
module tb_tlc_phase_sequencer;

    localparam int GREEN_MIN     = 4;
    localparam int EXT_STEP      = 2;
    localparam int GREEN_MAX     = 8;
    localparam int YELLOW_CYCLES = 3;
    localparam int WAIT_TIMEOUT  = 4;
    localparam int CNT_W         = 8;

    localparam int S_IDLE   = 0;
    localparam int S_GREEN  = 1;
    localparam int S_WAIT_Y = 2;
    localparam int S_YELLOW = 3;
    localparam int S_WAIT_G = 4;
    localparam int S_FAULT  = 5;

    logic             i_clock;
    logic             i_reset_b;
    logic             i_enable;
    logic [3:0]       i_green;
    logic [3:0]       i_yellow;
    logic [1:0]       i_w_sensor;
    logic [1:0]       i_s_sensor;
    logic [1:0]       i_e_sensor;
    logic [1:0]       i_n_sensor;
    logic             o_g2y_timer;
    logic             o_y2r_timer;
    logic [2:0]       o_state;
    logic [CNT_W-1:0] o_phase_cnt;
    logic             o_fault;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [3:0] green;
        logic [1:0] sens;
        int         dis_start;
        int         dis_len;
        int         exp_lat;
    } vec_t;

    vec_t vecs [8];

    tlc_phase_sequencer #(
        .GREEN_MIN     (GREEN_MIN),
        .EXT_STEP      (EXT_STEP),
        .GREEN_MAX     (GREEN_MAX),
        .YELLOW_CYCLES (YELLOW_CYCLES),
        .WAIT_TIMEOUT  (WAIT_TIMEOUT),
        .CNT_W         (CNT_W)
    ) dut (
        .i_clock     (i_clock),
        .i_reset_b   (i_reset_b),
        .i_enable    (i_enable),
        .i_green     (i_green),
        .i_yellow    (i_yellow),
        .i_w_sensor  (i_w_sensor),
        .i_s_sensor  (i_s_sensor),
        .i_e_sensor  (i_e_sensor),
        .i_n_sensor  (i_n_sensor),
        .o_g2y_timer (o_g2y_timer),
        .o_y2r_timer (o_y2r_timer),
        .o_state     (o_state),
        .o_phase_cnt (o_phase_cnt),
        .o_fault     (o_fault)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_target(input int s);
        int t;
        t = GREEN_MIN + EXT_STEP * s;
        return (t > GREEN_MAX) ? GREEN_MAX : t;
    endfunction

    function automatic int lane_of(input logic [3:0] g);
        int l;
        l = 0;
        for (int d = 0; d < 4; d++) begin
            if (g[d]) l = d;
        end
        return l;
    endfunction

    function automatic int sens_of(input logic [7:0] sv, input int lane);
        return int'((sv >> (2 * lane)) & 8'h03);
    endfunction

    task automatic set_sensors(input logic [7:0] sv);
        i_w_sensor = sv[1:0];
        i_s_sensor = sv[3:2];
        i_e_sensor = sv[5:4];
        i_n_sensor = sv[7:6];
    endtask

    task automatic apply_reset(input int n);
        i_reset_b = 1'b1;
        repeat (n) step();
        i_reset_b = 1'b0;
    endtask

    task automatic enter_green(input logic [3:0] g, input logic [7:0] sv);
        set_sensors(sv);
        i_green  = g;
        i_yellow = 4'b0000;
        i_enable = 1'b1;
        step();
        check("green_entry_state", int'(o_state), S_GREEN);
        check("green_entry_cnt", int'(o_phase_cnt), 0);
    endtask

    // Counts cycles from the first GREEN cycle until g2y is seen.
    task automatic green_run(input int dis_start, input int dis_len, output int lat);
        int k;
        k = 0;
        while (o_g2y_timer !== 1'b1 && k < 64) begin
            i_enable = (k >= dis_start && k < dis_start + dis_len) ? 1'b0 : 1'b1;
            step();
            k++;
        end
        lat = k;
        i_enable = 1'b1;
    endtask

    // Holds the current lamps for 'delay' cycles, then drives the acknowledge.
    task automatic hold_then_ack(input int delay, input logic [3:0] g, input logic [3:0] y,
                                 output int pulses);
        pulses = 0;
        for (int j = 0; j < delay && j < WAIT_TIMEOUT; j++) begin
            i_enable = 1'($urandom);
            step();
            if (o_g2y_timer || o_y2r_timer) pulses++;
        end
        if (delay < WAIT_TIMEOUT) begin
            i_green  = g;
            i_yellow = y;
            step();
            if (o_g2y_timer || o_y2r_timer) pulses++;
        end
    endtask

    // Counts cycles from the first YELLOW cycle until y2r is seen.
    task automatic yellow_run(output int lat);
        int k;
        k = 0;
        while (o_y2r_timer !== 1'b1 && k < 32) begin
            i_enable = 1'($urandom);
            step();
            k++;
        end
        lat = k;
    endtask

    task automatic fault_quiet(input string name);
        int pulses;
        int drops;
        pulses = 0;
        drops  = 0;
        i_green  = 4'b0100;
        i_yellow = 4'b0000;
        i_enable = 1'b1;
        repeat (8) begin
            step();
            if (o_g2y_timer || o_y2r_timer) pulses++;
            if (!o_fault || o_state != 3'(S_FAULT)) drops++;
        end
        check({name, "_pulses"}, pulses, 0);
        check({name, "_sticky"}, drops, 0);
    endtask

    initial begin
        int lat;
        int pulses;
        int bad;
        logic [7:0] sv;
        logic [3:0] g;
        int tgt, ds, dl, yd, gd, ln;

        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{4'b0001, 2'd0, 0, 0, 4};
        vecs[1] = '{4'b0001, 2'd1, 0, 0, 6};
        vecs[2] = '{4'b0001, 2'd3, 0, 0, 8};
        vecs[3] = '{4'b0010, 2'd2, 0, 0, 8};
        vecs[4] = '{4'b0100, 2'd1, 2, 0, 6};
        vecs[5] = '{4'b1000, 2'd0, 0, 0, 4};
        vecs[6] = '{4'b0001, 2'd0, 2, 5, 9};
        vecs[7] = '{4'b1000, 2'd2, 1, 3, 11};

        i_reset_b = 1'b0;
        i_enable  = 1'b0;
        i_green   = 4'b0001;
        i_yellow  = 4'b0000;
        set_sensors(8'h00);

        // Reset held three cycles, then released with enable low.
        bad = 0;
        i_reset_b = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) i_reset_b = 1'b0;
            step();
            if (o_g2y_timer || o_y2r_timer || o_fault || o_state != 3'(S_IDLE) || o_phase_cnt != '0)
                bad++;
        end
        check("reset_idle_outputs", bad, 0);
        check("reset_state", int'(o_state), S_IDLE);

        // IDLE must ignore lamp patterns that are not a clean single green.
        i_enable = 1'b1;
        i_yellow = 4'b0010;
        step(); step();
        check("idle_yellow_lit", int'(o_state), S_IDLE);
        i_yellow = 4'b0000;
        i_green  = 4'b0011;
        step(); step();
        check("idle_two_greens", int'(o_state), S_IDLE);

        // Directed vector table.
        for (int v = 0; v < 8; v++) begin
            apply_reset(2);
            ln = lane_of(vecs[v].green);
            for (int d = 0; d < 4; d++) begin
                sv[2*d +: 2] = (d == ln) ? vecs[v].sens : ~vecs[v].sens;
            end
            enter_green(vecs[v].green, sv);
            set_sensors(8'($urandom));
            green_run(vecs[v].dis_start, vecs[v].dis_len, lat);
            check($sformatf("vec%0d_g2y_lat", v), lat, vecs[v].exp_lat);
            check($sformatf("vec%0d_wait_y", v), int'(o_state), S_WAIT_Y);
            hold_then_ack(1, 4'b0000, vecs[v].green, pulses);
            check($sformatf("vec%0d_yellow", v), int'(o_state), S_YELLOW);
            check($sformatf("vec%0d_no_repeat", v), pulses, 0);
            yellow_run(lat);
            check($sformatf("vec%0d_y2r_lat", v), lat, YELLOW_CYCLES);
            i_green  = 4'b0000;
            i_yellow = 4'b0000;
            step();
            check($sformatf("vec%0d_y2r_once", v), int'(o_y2r_timer), 0);
        end

        // Counter holds while enable is low.
        apply_reset(1);
        enter_green(4'b0010, 8'h00);
        step(); step();
        i_enable = 1'b0;
        step(); step(); step();
        check("green_hold_cnt", int'(o_phase_cnt), 2);
        check("green_hold_state", int'(o_state), S_GREEN);

        // No yellow acknowledge: fault after exactly the timeout.
        apply_reset(1);
        enter_green(4'b0001, 8'h00);
        green_run(0, 0, lat);
        check("to_g2y_lat", lat, 4);
        step(); step(); step();
        check("to_before_fault", int'(o_fault), 0);
        check("to_before_state", int'(o_state), S_WAIT_Y);
        step();
        check("to_fault", int'(o_fault), 1);
        check("to_fault_state", int'(o_state), S_FAULT);
        fault_quiet("to");

        // Reset during YELLOW cancels the pending y2r.
        apply_reset(1);
        enter_green(4'b0100, 8'h00);
        green_run(0, 0, lat);
        hold_then_ack(0, 4'b0000, 4'b0100, pulses);
        check("rst_y_enter", int'(o_state), S_YELLOW);
        step();
        i_reset_b = 1'b1;
        step();
        i_reset_b = 1'b0;
        check("rst_y_state", int'(o_state), S_IDLE);
        check("rst_y_cnt", int'(o_phase_cnt), 0);
        pulses = int'(o_y2r_timer);
        repeat (6) begin
            step();
            if (o_y2r_timer || o_g2y_timer) pulses++;
        end
        check("rst_y_no_y2r", pulses, 0);
        check("rst_y_idle", int'(o_state), S_IDLE);

        // Green lamp pattern breaking during GREEN.
        apply_reset(1);
        enter_green(4'b1000, 8'h00);
        step();
        i_green = 4'b1001;
        step();
        check("green_break_state", int'(o_state), S_FAULT);
        check("green_break_fault", int'(o_fault), 1);
        fault_quiet("gb");

        // Randomized phase sequences against the timing model.
        for (int r = 0; r < 30; r++) begin
            apply_reset(1);
            g  = 4'(1 << $urandom_range(0, 3));
            sv = 8'($urandom);
            enter_green(g, sv);
            for (int p = 0; p < 5; p++) begin
                tgt = exp_target(sens_of(sv, lane_of(g)));
                set_sensors(8'($urandom));
                ds = int'($urandom_range(0, tgt - 1));
                dl = int'($urandom_range(0, 4));
                green_run(ds, dl, lat);
                check("rnd_g2y_lat", lat, tgt + dl);
                yd = int'($urandom_range(0, WAIT_TIMEOUT));
                hold_then_ack(yd, 4'b0000, g, pulses);
                check("rnd_wy_pulses", pulses, 0);
                if (yd >= WAIT_TIMEOUT) begin
                    check("rnd_wy_fault", int'(o_fault), 1);
                    fault_quiet("rnd_wy");
                    break;
                end
                check("rnd_yellow", int'(o_state), S_YELLOW);
                yellow_run(lat);
                check("rnd_y2r_lat", lat, YELLOW_CYCLES);
                i_green  = 4'b0000;
                i_yellow = 4'b0000;
                g  = 4'(1 << $urandom_range(0, 3));
                sv = 8'($urandom);
                set_sensors(sv);
                gd = int'($urandom_range(0, WAIT_TIMEOUT));
                hold_then_ack(gd, g, 4'b0000, pulses);
                check("rnd_wg_pulses", pulses, 0);
                if (gd >= WAIT_TIMEOUT) begin
                    check("rnd_wg_fault", int'(o_fault), 1);
                    fault_quiet("rnd_wg");
                    break;
                end
                check("rnd_regreen", int'(o_state), S_GREEN);
                check("rnd_regreen_cnt", int'(o_phase_cnt), 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
